// File: rtl/cl_pkg.sv
// cl_pkg: shared encodings and status-word layout for the capture-control sequencer.
package cl_pkg;

  localparam int N_FRAME_SIZE = 20;
  localparam int OP_W         = 12;
  localparam int ARG_W        = 20;
  localparam int TIMEOUT_W    = 20;
  localparam int WDT_CNT_W    = 30;
  localparam int OVF_W        = 16;
  localparam int BAD_W        = 8;
  localparam int RESULT_W     = 4;
  localparam int STAT_W       = 128;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARMED     = 2'd1;
  localparam logic [1:0] ST_CAPTURING = 2'd2;
  localparam logic [1:0] ST_REPORT    = 2'd3;

  localparam logic [OP_W-1:0] OP_ARM         = 12'd1;
  localparam logic [OP_W-1:0] OP_ABORT       = 12'd2;
  localparam logic [OP_W-1:0] OP_STATUS      = 12'd3;
  localparam logic [OP_W-1:0] OP_SET_TIMEOUT = 12'd4;

  localparam logic [RESULT_W-1:0] RES_OK       = 4'd0;
  localparam logic [RESULT_W-1:0] RES_ABORT    = 4'd1;
  localparam logic [RESULT_W-1:0] RES_TIMEOUT  = 4'd2;
  localparam logic [RESULT_W-1:0] RES_OVERFLOW = 4'd3;
  localparam logic [RESULT_W-1:0] RES_QUERY    = 4'd4;

  localparam logic [7:0] STAT_MARKER = 8'hFF;

  localparam int STAT_MARKER_LSB = 120;
  localparam int STAT_STATE_LSB  = 118;
  localparam int STAT_RESULT_LSB = 114;
  localparam int STAT_NFRAME_LSB = 94;
  localparam int STAT_FRAMES_LSB = 74;
  localparam int STAT_OVF_LSB    = 58;
  localparam int STAT_BAD_LSB    = 50;

  typedef struct packed {
    logic [1:0]              state;
    logic [RESULT_W-1:0]     result;
    logic [N_FRAME_SIZE-1:0] n_frame;
    logic [N_FRAME_SIZE-1:0] frames;
    logic [OVF_W-1:0]        ovf;
    logic [BAD_W-1:0]        bad;
  } stat_fields_t;

  function automatic logic [STAT_W-1:0] pack_stat(input stat_fields_t s);
    logic [STAT_W-1:0] v;
    v = '0;
    v[STAT_MARKER_LSB +: 8]            = STAT_MARKER;
    v[STAT_STATE_LSB  +: 2]            = s.state;
    v[STAT_RESULT_LSB +: RESULT_W]     = s.result;
    v[STAT_NFRAME_LSB +: N_FRAME_SIZE] = s.n_frame;
    v[STAT_FRAMES_LSB +: N_FRAME_SIZE] = s.frames;
    v[STAT_OVF_LSB    +: OVF_W]        = s.ovf;
    v[STAT_BAD_LSB    +: BAD_W]        = s.bad;
    return v;
  endfunction

endpackage

// File: rtl/cl_watchdog.sv
// cl_watchdog: inactivity timer with a limit in units of 1024 cycles; limit 0 disables it.
module cl_watchdog
  import cl_pkg::*;
(
  input  logic                 bus_clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);

  logic [WDT_CNT_W-1:0] r_count;
  logic [WDT_CNT_W-1:0] w_limit_cyc;

  assign w_limit_cyc = {limit, 10'd0};

  // Counting stops at the limit so a single expiry cannot repeat on wrap-around.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count < w_limit_cyc)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = enable && !clear && (limit != '0) &&
                  (r_count == (w_limit_cyc - 1'b1));

endmodule

// File: rtl/cl_seq.sv
// cl_seq: capture-control sequencer. Decodes host command words, arms and aborts the
// capture datapath, supervises it with a watchdog and offers one status word per run.
module cl_seq
  import cl_pkg::*;
(
  input  logic                    bus_clk,
  input  logic                    reset,
  input  logic                    pc_msg_pending,
  input  logic [31:0]             pc_msg,
  output logic                    pc_msg_ack,
  output logic                    cap_arm,
  output logic [N_FRAME_SIZE-1:0] cap_n_frame,
  output logic                    cap_abort,
  input  logic                    cap_frame,
  input  logic                    cap_done,
  input  logic                    cap_overflow,
  input  logic                    fpga_msg_full,
  output logic [127:0]            stat_msg,
  output logic                    stat_valid,
  output logic [1:0]              state
);

  // state     | meaning
  // IDLE      | waiting for ARM or STATUS
  // ARMED     | datapath started, waiting for its first frame or done
  // CAPTURING | counting frames toward cap_n_frame
  // REPORT    | status word offered until the host FIFO accepts it

  logic [1:0]              r_state, w_state_nxt;
  logic                    r_ack, r_cap_arm, r_cap_abort;
  logic [N_FRAME_SIZE-1:0] r_n_frame, r_frames, w_frames_nxt;
  logic [OVF_W-1:0]        r_ovf, w_ovf_nxt;
  logic [BAD_W-1:0]        r_bad, w_bad_nxt;
  logic [TIMEOUT_W-1:0]    r_timeout;
  logic [STAT_W-1:0]       r_stat_msg;

  logic [OP_W-1:0]         w_op;
  logic [ARG_W-1:0]        w_arg;
  logic                    w_cmd, w_active, w_capturing, w_report;
  logic                    w_known_op, w_arm_go, w_bad_inc, w_abort_req;
  logic                    w_status_idle, w_set_timeout, w_complete, w_expire;
  logic                    w_ack_nxt, w_enter_report, w_abort_pulse;
  logic [RESULT_W-1:0]     w_result;
  stat_fields_t            w_stat;

  assign w_op  = pc_msg[31:20];
  assign w_arg = pc_msg[19:0];

  // A command word is executed in its ack cycle, while the host still presents it.
  assign w_cmd       = r_ack;
  assign w_active    = (r_state == ST_ARMED) || (r_state == ST_CAPTURING);
  assign w_capturing = (r_state == ST_CAPTURING);
  assign w_report    = (r_state == ST_REPORT);

  assign w_known_op    = (w_op == OP_ARM) || (w_op == OP_ABORT) ||
                         (w_op == OP_STATUS) || (w_op == OP_SET_TIMEOUT);
  assign w_arm_go      = w_cmd && (w_op == OP_ARM) && (r_state == ST_IDLE) && (w_arg != '0);
  assign w_bad_inc     = w_cmd && (((w_op == OP_ARM) && !w_arm_go) || !w_known_op);
  assign w_abort_req   = w_cmd && (w_op == OP_ABORT) && w_active;
  assign w_status_idle = w_cmd && (w_op == OP_STATUS) && (r_state == ST_IDLE);
  assign w_set_timeout = w_cmd && (w_op == OP_SET_TIMEOUT);

  // Only SET_TIMEOUT and STATUS may be consumed while a report is pending.
  assign w_ack_nxt = pc_msg_pending && !r_ack &&
                     (!w_report || (w_op == OP_SET_TIMEOUT) || (w_op == OP_STATUS));

  assign w_frames_nxt = (w_active && cap_frame) ? r_frames + 1'b1 : r_frames;
  assign w_ovf_nxt    = (w_capturing && cap_overflow && (r_ovf != '1)) ? r_ovf + 1'b1 : r_ovf;
  assign w_bad_nxt    = (w_bad_inc && (r_bad != '1)) ? r_bad + 1'b1 : r_bad;
  assign w_complete   = w_capturing && (cap_done || (w_frames_nxt == r_n_frame));

  cl_watchdog u_watchdog (
    .bus_clk (bus_clk),
    .reset   (reset),
    .clear   (w_arm_go || cap_frame),
    .enable  (w_active),
    .limit   (r_timeout),
    .expire  (w_expire)
  );

  // Completion outranks abort and expiry; abort outranks expiry.
  always_comb begin
    w_state_nxt    = r_state;
    w_result       = RES_OK;
    w_enter_report = 1'b0;
    w_abort_pulse  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arm_go) begin
          w_state_nxt = ST_ARMED;
        end else if (w_status_idle) begin
          w_state_nxt    = ST_REPORT;
          w_result       = RES_QUERY;
          w_enter_report = 1'b1;
        end
      end
      ST_ARMED: begin
        if (w_abort_req) begin
          w_state_nxt    = ST_REPORT;
          w_result       = RES_ABORT;
          w_enter_report = 1'b1;
          w_abort_pulse  = 1'b1;
        end else if (w_expire) begin
          w_state_nxt    = ST_REPORT;
          w_result       = RES_TIMEOUT;
          w_enter_report = 1'b1;
          w_abort_pulse  = 1'b1;
        end else if (cap_frame || cap_done) begin
          w_state_nxt = ST_CAPTURING;
        end
      end
      ST_CAPTURING: begin
        if (w_complete) begin
          w_state_nxt    = ST_REPORT;
          w_result       = (w_ovf_nxt != '0) ? RES_OVERFLOW : RES_OK;
          w_enter_report = 1'b1;
        end else if (w_abort_req) begin
          w_state_nxt    = ST_REPORT;
          w_result       = RES_ABORT;
          w_enter_report = 1'b1;
          w_abort_pulse  = 1'b1;
        end else if (w_expire) begin
          w_state_nxt    = ST_REPORT;
          w_result       = RES_TIMEOUT;
          w_enter_report = 1'b1;
          w_abort_pulse  = 1'b1;
        end
      end
      ST_REPORT: begin
        if (!fpga_msg_full) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stat         = '0;
    w_stat.state   = r_state;
    w_stat.result  = w_result;
    w_stat.n_frame = r_n_frame;
    w_stat.frames  = w_frames_nxt;
    w_stat.ovf     = w_ovf_nxt;
    w_stat.bad     = w_bad_nxt;
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ack       <= 1'b0;
      r_cap_arm   <= 1'b0;
      r_cap_abort <= 1'b0;
      r_bad       <= '0;
      r_timeout   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack       <= w_ack_nxt;
      r_cap_arm   <= w_arm_go;
      r_cap_abort <= w_abort_pulse;
      r_bad       <= w_bad_nxt;
      if (w_set_timeout) begin
        r_timeout <= w_arg;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      r_n_frame  <= '0;
      r_frames   <= '0;
      r_ovf      <= '0;
      r_stat_msg <= '0;
    end else begin
      if (w_arm_go) begin
        r_n_frame <= w_arg;
        r_frames  <= '0;
        r_ovf     <= '0;
      end else begin
        r_frames <= w_frames_nxt;
        r_ovf    <= w_ovf_nxt;
      end
      if (w_enter_report) begin
        r_stat_msg <= pack_stat(w_stat);
      end
    end
  end

  assign pc_msg_ack  = r_ack;
  assign cap_arm     = r_cap_arm;
  assign cap_abort   = r_cap_abort;
  assign cap_n_frame = r_n_frame;
  assign stat_msg    = r_stat_msg;
  assign stat_valid  = w_report;
  assign state       = r_state;

endmodule

// File: doc/cl_seq.md
CL_SEQ -- requirements
Module: cl_seq

Interface
REQ-001 SHALL have ports: bus_clk in 1, capture-control clock; all logic is on rising edge.
REQ-002 SHALL have reset in 1, synchronous, active-high.
REQ-003 SHALL have pc_msg_pending in 1: a host command word is present.
REQ-004 SHALL have pc_msg in 32: [31:20] opcode, [19:0] argument.
REQ-005 SHALL have pc_msg_ack out 1: one-cycle pulse that consumes the command.
REQ-006 SHALL have cap_arm out 1: one-cycle pulse that starts the capture datapath.
REQ-007 SHALL have cap_n_frame out 20: frame count, held stable from arm until return to IDLE.
REQ-008 SHALL have cap_abort out 1: one-cycle pulse that stops the datapath.
REQ-009 SHALL have cap_frame in 1 (one-cycle pulse per completed frame), cap_done in 1 (pulse) and cap_overflow in 1 (level).
REQ-010 SHALL have fpga_msg_full in 1, stat_msg out 128 and stat_valid out 1 (status word toward the host FIFO).
REQ-011 SHALL have state out 2: current state, for LEDs.

Function
REQ-012 States SHALL be IDLE=0, ARMED=1, CAPTURING=2, REPORT=3.
REQ-013 Opcodes SHALL be 1 ARM(n), 2 ABORT, 3 STATUS, 4 SET_TIMEOUT(t); any other opcode increments bad_cmd (8b, saturating) and is acked.
REQ-014 Command acceptance: when pc_msg_pending && !pc_msg_ack, pc_msg_ack SHALL assert the next cycle; acks are never back-to-back.
REQ-015 ARM SHALL be accepted only in IDLE with n!=0: latch n into cap_n_frame, pulse cap_arm the cycle after ack, go to ARMED.
REQ-016 ARM in any other state, or ARM with n=0, SHALL only increment bad_cmd.
REQ-017 ARMED SHALL go to CAPTURING on the first cap_frame or cap_done; cap_frame increments frames_done (20b, cleared on arm).
REQ-018 CAPTURING SHALL go to REPORT on cap_done, or on frames_done reaching cap_n_frame (result OK=0).
REQ-019 ABORT in ARMED or CAPTURING SHALL pulse cap_abort and go to REPORT with result ABORT=1; ABORT in IDLE SHALL be acked with no effect.
REQ-020 Watchdog: timeout register (20b, reset 0 = disabled) in units of 1024 cycles; a 30b counter clears on each cap_frame and on entry to ARMED.
REQ-021 On watchdog expiry in ARMED or CAPTURING, the block SHALL pulse cap_abort and go to REPORT with result TIMEOUT=2.
REQ-022 SET_TIMEOUT SHALL be accepted in any state and take effect the next cycle.
REQ-023 Every cycle with cap_overflow high and state CAPTURING SHALL increment ovf_cnt (16b, saturating, cleared on arm); a nonzero ovf_cnt at an OK completion changes the result to OVERFLOW=3.
REQ-024 STATUS in IDLE SHALL go to REPORT with result QUERY=4; STATUS in any other state is acked and deferred into the next REPORT.
REQ-025 stat_msg layout SHALL be: [127:120]=8'hFF marker, [119:118]=state at entry to REPORT, [117:114]=result, [113:94]=cap_n_frame, [93:74]=frames_done, [73:58]=ovf_cnt, [57:50]=bad_cmd, [49:0]=0.
REQ-026 stat_msg SHALL be registered on REPORT entry; stat_valid is high throughout REPORT.
REQ-027 The word SHALL transfer on a cycle where stat_valid && !fpga_msg_full; that transfer returns the block to IDLE the next cycle.
REQ-028 While fpga_msg_full is high, REPORT SHALL hold with stat_msg unchanged.
REQ-029 Simultaneous events: cap_done with ABORT SHALL resolve to OK; watchdog expiry with cap_done SHALL resolve to OK; ABORT with expiry SHALL resolve to ABORT.
REQ-030 Commands arriving during REPORT SHALL wait unacked, except SET_TIMEOUT and STATUS.

Reset
REQ-031 Reset SHALL force state=IDLE, all counters and the timeout register to 0, and every output to 0.
REQ-032 Reset in any state SHALL take effect at the next edge with no cap_abort pulse; any pending report is discarded.

Structure
REQ-033 Package cl_pkg SHALL hold the state encoding, opcodes, result codes, N_FRAME_SIZE=20, the 8'hFF marker and the stat_msg field offsets.
REQ-034 Sub-module cl_watchdog SHALL hold the watchdog (inputs: clear, enable, limit; output: one-cycle expire pulse).

Verification
REQ-035 ARM(3), then 3 cap_frame pulses -> one cap_arm, stat_msg result 0, frames_done=3, return to IDLE.
REQ-036 SET_TIMEOUT(1), ARM(5), no frames -> cap_abort 1024 cycles after ARMED entry, result 2.
REQ-037 ARM(10), ABORT after 4 frames -> cap_abort pulse, result 1, frames_done=4.
REQ-038 In REPORT, hold fpga_msg_full high for 50 cycles -> stat_valid and stat_msg stable; single transfer on release.
REQ-039 Opcode 7, then ARM while CAPTURING -> bad_cmd=2; both acked; capture unaffected.
REQ-040 cap_overflow high for 20 cycles, then cap_done -> ovf_cnt=20, result 3; reset mid-CAPTURING -> IDLE, all outputs 0.
